fir_axilite_cfg: RTL and testbench

- AXI-Lite slave that sits directly upstream of the FIR ap-control FSM.
- Decodes host writes into a one-cycle config_write_address/config_write_data strobe, which the FSM uses to detect the ap_start write.
- Holds the data_length register.
- Arbitrates host access to the single-port tap-coefficient RAM.
- Returns ap_ctrl status and register/tap readback.

---
 rtl/fir_axilite_cfg.sv | 135 +++++++++++++
 tb/tb_fir_axilite_cfg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axilite_cfg.sv
// AXI-Lite configuration slave for the FIR: ap_ctrl/data_length registers,
// config write strobe toward the ap FSM, and host access to the tap RAM.
module fir_axilite_cfg #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pADDR_WIDTH-1:0] config_write_address,
    output logic [pDATA_WIDTH-1:0] config_write_data,
    output logic [31:0]            data_length,
    input  logic                   ap_start,
    input  logic                   ap_done,
    input  logic                   ap_idle,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32'h20 + 4 * Tape_Num);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= TAP_BASE) && (a < TAP_END);
    endfunction

    logic                   w_acc_q, w_acc_d;
    logic [pADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [pDATA_WIDTH-1:0] cfg_data_q, cfg_data_d;
    logic [31:0]            len_q, len_d;
    rstate_t                state_q, state_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   ram_wr, ar_block, rd_en;
    logic [pADDR_WIDTH-1:0] rd_a;

    // Accept fires the cycle after both valids are seen; the ~w_acc_q term
    // keeps the still-high valids of the accept cycle from re-triggering.
    assign w_acc_d    = awvalid & wvalid & ~w_acc_q;
    assign awready    = w_acc_q;
    assign wready     = w_acc_q;
    assign cfg_addr_d = w_acc_q ? awaddr : '1;
    assign cfg_data_d = w_acc_q ? wdata : '0;
    assign len_d      = (w_acc_q && awaddr == ADDR_LEN) ? 32'(wdata) : len_q;

    assign ram_wr   = w_acc_q & is_tap(awaddr) & ap_idle;
    // Write owns the single RAM port; a colliding tap read is stalled a cycle.
    assign ar_block = ram_wr & arvalid & is_tap(araddr);

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            w_acc_q    <= 1'b0;
            cfg_addr_q <= '1;
            cfg_data_q <= '0;
            len_q      <= '0;
            state_q    <= R_IDLE;
            rdata_q    <= '0;
        end else begin
            w_acc_q    <= w_acc_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            len_q      <= len_d;
            state_q    <= state_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        arready = 1'b0;
        rvalid  = 1'b0;
        rd_en   = 1'b0;
        rd_a    = '0;
        case (state_q)
            R_IDLE: begin
                arready = ~ar_block;
                if (arvalid && !ar_block) begin
                    if (is_tap(araddr) && ap_idle) begin
                        rd_en   = ~axis_rst;
                        rd_a    = araddr - TAP_BASE;
                        state_d = R_WAIT;
                    end else begin
                        state_d = R_DATA;
                        rdata_d = '0;
                        if (is_tap(araddr))
                            rdata_d = '1;
                        else if (araddr == ADDR_CTRL)
                            rdata_d[2:0] = {ap_idle, ap_done, ap_start};
                        else if (araddr == ADDR_LEN)
                            rdata_d = pDATA_WIDTH'(len_q);
                    end
                end
            end
            R_WAIT: begin
                rdata_d = tap_Do;
                state_d = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign tap_EN = ram_wr | rd_en;
    assign tap_WE = ram_wr ? 4'hF : 4'h0;
    assign tap_A  = ram_wr ? (awaddr - TAP_BASE) : rd_a;
    assign tap_Di = wdata;

    assign rdata                = rdata_q;
    assign config_write_address = cfg_addr_q;
    assign config_write_data    = cfg_data_q;
    assign data_length          = len_q;

endmodule

// File: tb/tb_fir_axilite_cfg.sv
// Scoreboard bench for fir_axilite_cfg: drivers queue expected strobes, tap
// writes and read responses; a negedge monitor pops and compares them.
module tb_fir_axilite_cfg;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic [11:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic        awready, wready, arready, rvalid;
    logic [31:0] rdata, config_write_data, data_length, tap_Di;
    logic [11:0] config_write_address, tap_A;
    logic        ap_start = 1'b0, ap_done = 1'b0, ap_idle = 1'b1;
    logic        tap_EN;
    logic [3:0]  tap_WE;
    logic [31:0] tap_Do = '0;

    fir_axilite_cfg #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .config_write_address(config_write_address), .config_write_data(config_write_data),
        .data_length(data_length),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do)
    );

    always #5 axis_clk = ~axis_clk;

    logic [31:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    typedef struct { logic [31:0] data; int lat; } rd_exp_t;
    typedef struct { logic [11:0] a; logic [31:0] d; } aw_exp_t;
    rd_exp_t rd_q[$];
    aw_exp_t cfg_q[$], tap_q[$];
    rd_exp_t re;
    aw_exp_t ce, te;

    int errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
    logic rv_prev = 1'b0;
    logic [31:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    always @(posedge axis_clk) cyc++;

    always @(negedge axis_clk) begin
        if (axis_rst) begin
            rv_prev = 1'b0;
        end else begin
            if (arvalid && arready) acc_cyc = cyc;
            if (config_write_address != 12'hFFF) begin
                if (cfg_q.size() == 0) fail_now($sformatf("cfg_strobe_unexpected addr=%h", config_write_address));
                else begin
                    ce = cfg_q.pop_front();
                    chk("cfg_addr", {20'h0, config_write_address}, {20'h0, ce.a});
                    chk("cfg_data", config_write_data, ce.d);
                end
            end else chk("cfg_idle_data", config_write_data, 32'h0);
            if (tap_WE != 4'h0) begin
                if (tap_q.size() == 0) fail_now($sformatf("tap_write_unexpected A=%h", tap_A));
                else begin
                    te = tap_q.pop_front();
                    chk("tap_WE", {28'h0, tap_WE}, 32'hF);
                    chk("tap_EN_wr", {31'h0, tap_EN}, 32'h1);
                    chk("tap_A_wr", {20'h0, tap_A}, {20'h0, te.a});
                    chk("tap_Di", tap_Di, te.d);
                end
            end
            if (rvalid && !rv_prev) begin
                held = rdata;
                if (rd_q.size() == 0) fail_now("rvalid_unexpected");
                else chk("rd_latency", cyc - acc_cyc, rd_q[0].lat);
            end else if (rvalid) chk("rd_hold", rdata, held);
            if (rvalid && rready && rd_q.size() > 0) begin
                re = rd_q.pop_front();
                chk("rd_data", rdata, re.data);
            end
            rv_prev = rvalid;
        end
    end

    function automatic logic is_tap(input logic [11:0] a);
        return (a >= 12'h20) && (a < 12'h4C);
    endfunction

    task automatic wait_sig(input string name, input int which);
        int n = 0;
        while (1) begin
            @(negedge axis_clk);
            if ((which == 0 && awready) || (which == 1 && arready) || (which == 2 && rvalid)) break;
            if (++n > 20) begin fail_now({name, "_timeout"}); break; end
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input int aw_lead);
        cfg_q.push_back(aw_exp_t'{a, d});
        if (is_tap(a) && ap_idle) tap_q.push_back(aw_exp_t'{a - 12'h20, d});
        @(posedge axis_clk); #1;
        awaddr = a; wdata = d; awvalid = 1'b1;
        repeat (aw_lead) begin
            @(negedge axis_clk);
            chk("awready_without_wvalid", {31'h0, awready}, 32'h0);
            @(posedge axis_clk); #1;
        end
        wvalid = 1'b1;
        wait_sig("awready", 0);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input int lat, input int hold);
        rd_q.push_back(rd_exp_t'{exp, lat});
        @(posedge axis_clk); #1;
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        wait_sig("arready", 1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        wait_sig("rvalid", 2);
        repeat (hold) begin
            @(negedge axis_clk);
            chk("rvalid_while_stalled", {31'h0, rvalid}, 32'h1);
        end
        if (hold > 0) begin
            @(posedge axis_clk); #1;
            rready = 1'b1;
            @(negedge axis_clk);
        end
        @(posedge axis_clk); #1;
    endtask

    int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    initial begin
        repeat (2) @(negedge axis_clk);
        chk("rst_awready", {31'h0, awready}, 32'h0);
        chk("rst_wready", {31'h0, wready}, 32'h0);
        chk("rst_arready", {31'h0, arready}, 32'h1);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_data_length", data_length, 32'h0);
        chk("rst_cfg_addr", {20'h0, config_write_address}, 32'hFFF);
        chk("rst_cfg_data", config_write_data, 32'h0);
        chk("rst_tap_EN", {31'h0, tap_EN}, 32'h0);
        chk("rst_tap_WE", {28'h0, tap_WE}, 32'h0);
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;

        wr(12'h10, 32'd600, 2);
        chk("data_length_600", data_length, 32'd600);
        rd(12'h10, 32'd600, 1, 0);

        ap_idle = 1'b1;
        for (int i = 0; i < 11; i++) wr(12'h20 + 12'(4 * i), 32'(taps[i]), 0);
        for (int i = 0; i < 11; i++) rd(12'h20 + 12'(4 * i), 32'(taps[i]), 2, 0);

        ap_idle = 1'b0;
        wr(12'h24, 32'd7, 0);
        rd(12'h24, 32'hFFFFFFFF, 1, 0);
        ap_idle = 1'b1;
        rd(12'h24, 32'hFFFFFFF6, 2, 0);

        wr(12'h000, 32'd1, 0);
        ap_done = 1'b1;
        rd(12'h000, 32'd6, 1, 0);
        ap_start = 1'b1; ap_done = 1'b0; ap_idle = 1'b0;
        rd(12'h000, 32'd1, 1, 0);
        ap_start = 1'b0; ap_idle = 1'b1;

        wr(12'h100, 32'd55, 0);
        rd(12'h100, 32'h0, 1, 0);
        rd(12'h10, 32'd600, 1, 0);

        // Tap write accept and tap read request land in the same cycle.
        cfg_q.push_back(aw_exp_t'{12'h28, 32'd99});
        tap_q.push_back(aw_exp_t'{12'h08, 32'd99});
        rd_q.push_back(rd_exp_t'{32'd99, 2});
        @(posedge axis_clk); #1;
        awaddr = 12'h28; wdata = 32'd99; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge axis_clk);
        chk("cf_awready_pre", {31'h0, awready}, 32'h0);
        @(posedge axis_clk); #1;
        araddr = 12'h28; arvalid = 1'b1; rready = 1'b0;
        @(negedge axis_clk);
        chk("cf_awready", {31'h0, awready}, 32'h1);
        chk("cf_arready_blocked", {31'h0, arready}, 32'h0);
        @(posedge axis_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge axis_clk);
        chk("cf_arready_next", {31'h0, arready}, 32'h1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        wait_sig("cf_rvalid", 2);
        repeat (5) begin
            @(negedge axis_clk);
            chk("cf_rvalid_stalled", {31'h0, rvalid}, 32'h1);
        end
        @(posedge axis_clk); #1;
        rready = 1'b1;
        @(negedge axis_clk);
        @(posedge axis_clk); #1;

        // Reset lands while a tap read sits in R_WAIT.
        araddr = 12'h20; arvalid = 1'b1;
        wait_sig("rst_ar", 1);
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        axis_rst = 1'b1;
        @(negedge axis_clk);
        chk("midrst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("midrst_arready", {31'h0, arready}, 32'h1);
        chk("midrst_cfg_addr", {20'h0, config_write_address}, 32'hFFF);
        chk("midrst_data_length", data_length, 32'h0);
        chk("midrst_tap_EN", {31'h0, tap_EN}, 32'h0);
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        repeat (3) @(negedge axis_clk);
        chk("post_rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rd_q_empty", rd_q.size(), 32'h0);
        chk("cfg_q_empty", cfg_q.size(), 32'h0);
        chk("tap_q_empty", tap_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
